// File: rtl/btle_adv_scheduler.sv
// btle_adv_scheduler
// Advertising-event sequencer feeding the baremetal PHY-TX port of btle_controller.
// Owns a 64-octet host-written PDU buffer, copies the first L octets into the PHY
// PDU memory, then sends the PDU on each enabled primary channel (37, 38, 39) in
// ascending order with a fixed gap, and repeats after a programmable interval.
//
// Optional feature macro: BTLE_ADV_SCHED_TX_TIMEOUT_EN
//   defined   -> WAIT_TX watchdog; after TX_TIMEOUT_CYCLES without tx_iq_valid_last,
//                tx_timeout pulses, the event is abandoned and the FSM enters INTERVAL.
//   undefined -> tx_timeout tied 0, WAIT_TX waits indefinitely.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   enable                      run advertising events while high
//   channel_map[2:0]            bit0=ch37, bit1=ch38, bit2=ch39
//   adv_interval_us[23:0]       idle time after each event in us (0 -> 1 cycle)
//   pdu_len[5:0]                octets to send, clamped to 2..39
//   pdu_wr_en/addr/data         host buffer write port
//   tx_preamble, tx_access_address, tx_crc_state_init_bit   constants
//   tx_crc_state_init_bit_load, tx_channel_number_load      CFG pulses
//   tx_channel_number           current channel
//   tx_pdu_octet_mem_addr/data  PHY PDU memory write (held outside LOAD)
//   tx_start                    PHY start pulse
//   tx_iq_valid_last            end-of-packet from the PHY
//   busy, event_done, tx_timeout status

module btle_adv_scheduler #(
  parameter int unsigned CLK_FREQUENCE            = 16_000_000,
  parameter int unsigned CRC_STATE_BIT_WIDTH      = 24,
  parameter int unsigned CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int unsigned GAP_CYCLES               = 2400,
  parameter int unsigned TX_TIMEOUT_CYCLES        = 65535
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [2:0]                          channel_map,
  input  logic [23:0]                         adv_interval_us,
  input  logic [5:0]                          pdu_len,
  input  logic                                pdu_wr_en,
  input  logic [5:0]                          pdu_wr_addr,
  input  logic [7:0]                          pdu_wr_data,
  output logic [7:0]                          tx_preamble,
  output logic [31:0]                         tx_access_address,
  output logic [CRC_STATE_BIT_WIDTH-1:0]      tx_crc_state_init_bit,
  output logic                                tx_crc_state_init_bit_load,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number,
  output logic                                tx_channel_number_load,
  output logic [5:0]                          tx_pdu_octet_mem_addr,
  output logic [7:0]                          tx_pdu_octet_mem_data,
  output logic                                tx_start,
  input  logic                                tx_iq_valid_last,
  output logic                                busy,
  output logic                                event_done,
  output logic                                tx_timeout
);

  localparam int unsigned TICKS_PER_US = CLK_FREQUENCE / 1_000_000;
  localparam int unsigned PRESC_W      = $clog2(TICKS_PER_US + 1);
  localparam int unsigned GAP_W        = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CH_W         = CHANNEL_NUMBER_BIT_WIDTH;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_CFG      = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT_TX  = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
  localparam logic [2:0] S_INTERVAL = 3'd6;

  // Constant PHY framing fields
  assign tx_preamble           = 8'hAA;
  assign tx_access_address     = 32'h8E89BED6;
  assign tx_crc_state_init_bit = CRC_STATE_BIT_WIDTH'(24'h555555);

  // Host PDU buffer (not reset)
  logic [7:0] mem_q [64];

  always_ff @(posedge clk) begin
    if (pdu_wr_en) mem_q[pdu_wr_addr] <= pdu_wr_data;
  end

  logic [2:0]         state_q, state_d;
  logic [2:0]         pending_q, pending_d;
  logic [5:0]         len_q, len_d;
  logic [5:0]         load_idx_q, load_idx_d;
  logic [5:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [CH_W-1:0]    chan_q, chan_d;
  logic               cfg_pulse_q, cfg_pulse_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [23:0]        us_cnt_q, us_cnt_d;

  logic [5:0] len_clamp_c;
  logic [5:0] rd_addr_c;
  logic       start_event_c;
  logic       enter_cfg_c;
  logic       interval_done_c;

`ifdef BTLE_ADV_SCHED_TX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TX_TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  assign tx_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TX_TIMEOUT_CYCLES == 0);
  assign tx_timeout = 1'b0;
`endif

  // Effective PDU length
  always_comb begin
    len_clamp_c = pdu_len;
    if (pdu_len < 6'd2)       len_clamp_c = 6'd2;
    else if (pdu_len > 6'd39) len_clamp_c = 6'd39;
  end

  // Interval expiry: 0 us means a single cycle in INTERVAL
  assign interval_done_c = (adv_interval_us == 24'd0) ||
                           ((presc_q == PRESC_W'(TICKS_PER_US - 1)) &&
                            (us_cnt_q == 24'(adv_interval_us - 24'd1)));

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    len_d         = len_q;
    load_idx_d    = load_idx_q;
    addr_d        = addr_q;
    data_d        = data_q;
    chan_d        = chan_q;
    gap_cnt_d     = gap_cnt_q;
    presc_d       = presc_q;
    us_cnt_d      = us_cnt_q;
    done_d        = 1'b0;
    rd_addr_c     = 6'd0;
    start_event_c = 1'b0;
    enter_cfg_c   = 1'b0;
`ifdef BTLE_ADV_SCHED_TX_TIMEOUT_EN
    timeout_d     = 1'b0;
    to_cnt_d      = (state_q == S_WAIT_TX) ? TO_W'(to_cnt_q + TO_W'(1)) : '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable && (channel_map != 3'b000)) start_event_c = 1'b1;
      end
      S_LOAD: begin
        if (load_idx_q == 6'(len_q - 6'd1)) begin
          enter_cfg_c = 1'b1;
        end else begin
          // Buffer is read one cycle ahead of the registered output
          rd_addr_c  = 6'(load_idx_q + 6'd1);
          load_idx_d = rd_addr_c;
          addr_d     = rd_addr_c;
          data_d     = mem_q[rd_addr_c];
        end
      end
      S_CFG:   state_d = S_START;
      S_START: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_iq_valid_last) begin
          if (pending_q != 3'b000) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            done_d = 1'b1;
            // enable low at event end skips INTERVAL entirely
            if (enable) begin
              state_d  = S_INTERVAL;
              presc_d  = '0;
              us_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
`ifdef BTLE_ADV_SCHED_TX_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TX_TIMEOUT_CYCLES - 2)) begin
          // Registered pulse lands TX_TIMEOUT_CYCLES after tx_start
          timeout_d = 1'b1;
          state_d   = S_INTERVAL;
          pending_d = 3'b000;
          presc_d   = '0;
          us_cnt_d  = '0;
        end
`endif
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) enter_cfg_c = 1'b1;
        else gap_cnt_d = GAP_W'(gap_cnt_q + GAP_W'(1));
      end
      S_INTERVAL: begin
        if (interval_done_c) begin
          if (enable && (channel_map != 3'b000)) start_event_c = 1'b1;
          else state_d = S_IDLE;
        end else if (presc_q == PRESC_W'(TICKS_PER_US - 1)) begin
          presc_d  = '0;
          us_cnt_d = 24'(us_cnt_q + 24'd1);
        end else begin
          presc_d = PRESC_W'(presc_q + PRESC_W'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    // New event: latch configuration and present octet 0
    if (start_event_c) begin
      state_d    = S_LOAD;
      pending_d  = channel_map;
      len_d      = len_clamp_c;
      load_idx_d = 6'd0;
      rd_addr_c  = 6'd0;
      addr_d     = 6'd0;
      data_d     = mem_q[rd_addr_c];
    end

    // Pick and retire the lowest pending channel
    if (enter_cfg_c) begin
      state_d = S_CFG;
      if (pending_q[0]) begin
        chan_d    = CH_W'(37);
        pending_d = pending_q & 3'b110;
      end else if (pending_q[1]) begin
        chan_d    = CH_W'(38);
        pending_d = pending_q & 3'b101;
      end else begin
        chan_d    = CH_W'(39);
        pending_d = pending_q & 3'b011;
      end
    end

    cfg_pulse_d = enter_cfg_c;
    start_d     = (state_q == S_CFG);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 3'b000;
      len_q       <= 6'd2;
      load_idx_q  <= 6'd0;
      addr_q      <= 6'd0;
      data_q      <= 8'd0;
      chan_q      <= '0;
      cfg_pulse_q <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gap_cnt_q   <= '0;
      presc_q     <= '0;
      us_cnt_q    <= 24'd0;
`ifdef BTLE_ADV_SCHED_TX_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      len_q       <= len_d;
      load_idx_q  <= load_idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      cfg_pulse_q <= cfg_pulse_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      gap_cnt_q   <= gap_cnt_d;
      presc_q     <= presc_d;
      us_cnt_q    <= us_cnt_d;
`ifdef BTLE_ADV_SCHED_TX_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign tx_crc_state_init_bit_load = cfg_pulse_q;
  assign tx_channel_number_load     = cfg_pulse_q;
  assign tx_channel_number          = chan_q;
  assign tx_pdu_octet_mem_addr      = addr_q;
  assign tx_pdu_octet_mem_data      = data_q;
  assign tx_start                   = start_q;
  assign busy                       = busy_q;
  assign event_done                 = done_q;

endmodule
